// File: rtl/card_pkg.sv
// Shared types and constants for the card sprite renderer and its deal animation.
package card_pkg;

    localparam int unsigned SCREEN_W = 256;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned SPR_W    = 16;
    localparam int unsigned SPR_H    = 32;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned STEP     = 2;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [7:0]         coord_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        MOVE,
        DONE
    } deal_state_t;

    localparam color_t TRANSPARENT = 3'b000;
    localparam color_t BLACK       = 3'b000;
    localparam color_t RED         = 3'b100;
    localparam color_t GREEN       = 3'b010;
    localparam color_t BLUE        = 3'b001;
    localparam color_t WHITE       = 3'b111;

    // Move one axis toward its target by at most 'step', never overshooting.
    function automatic coord_t step_toward(coord_t cur, coord_t tgt, coord_t step);
        coord_t res;
        if (cur < tgt) begin
            res = ((tgt - cur) > step) ? coord_t'(cur + step) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > step) ? coord_t'(cur - step) : tgt;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/card_deal_fsm.sv
// Deal animation: slides the card position from start to target, one step per frame.
module card_deal_fsm #(
    parameter int unsigned STEP = card_pkg::STEP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       deal_start,
    input  logic [7:0] start_x,
    input  logic [7:0] start_y,
    input  logic [7:0] target_x,
    input  logic [7:0] target_y,
    output logic [7:0] cur_x,
    output logic [7:0] cur_y,
    output logic       busy,
    output logic       done
);
    import card_pkg::*;

    deal_state_t state, state_nxt;
    coord_t      cur_x_nxt, cur_y_nxt;
    coord_t      pend_sx, pend_sy, pend_tx, pend_ty;
    coord_t      pend_sx_nxt, pend_sy_nxt, pend_tx_nxt, pend_ty_nxt;
    coord_t      step_x, step_y;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            pend_sx <= '0;
            pend_sy <= '0;
            pend_tx <= '0;
            pend_ty <= '0;
        end else begin
            state   <= state_nxt;
            cur_x   <= cur_x_nxt;
            cur_y   <= cur_y_nxt;
            pend_sx <= pend_sx_nxt;
            pend_sy <= pend_sy_nxt;
            pend_tx <= pend_tx_nxt;
            pend_ty <= pend_ty_nxt;
        end
    end

    always_comb begin
        step_x      = step_toward(cur_x, pend_tx, coord_t'(STEP));
        step_y      = step_toward(cur_y, pend_ty, coord_t'(STEP));
        state_nxt   = state;
        cur_x_nxt   = cur_x;
        cur_y_nxt   = cur_y;
        pend_sx_nxt = pend_sx;
        pend_sy_nxt = pend_sy;
        pend_tx_nxt = pend_tx;
        pend_ty_nxt = pend_ty;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                // Only IDLE accepts a request, so a busy deal keeps its pending values.
                if (deal_start) begin
                    pend_sx_nxt = start_x;
                    pend_sy_nxt = start_y;
                    pend_tx_nxt = target_x;
                    pend_ty_nxt = target_y;
                    state_nxt   = PENDING;
                end
            end
            PENDING: begin
                busy = 1'b1;
                if (frame_start) begin
                    cur_x_nxt = pend_sx;
                    cur_y_nxt = pend_sy;
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                busy = 1'b1;
                if (frame_start) begin
                    cur_x_nxt = step_x;
                    cur_y_nxt = step_y;
                    if (step_x == pend_tx && step_y == pend_ty) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // busy stays high through the done pulse and drops with the return to IDLE.
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/card_sprite_renderer.sv
// Maps the pixel stream onto sprite RAM addresses and composites the returned
// sprite pixel over the background, with the card placed by the deal FSM.
module card_sprite_renderer #(
    parameter int unsigned SPR_W                   = card_pkg::SPR_W,
    parameter int unsigned SPR_H                   = card_pkg::SPR_H,
    parameter int unsigned ADDR_W                  = card_pkg::ADDR_W,
    parameter int unsigned COLOR_W                 = card_pkg::COLOR_W,
    parameter int unsigned STEP                    = card_pkg::STEP,
    parameter logic [COLOR_W-1:0] TRANSPARENT      = card_pkg::TRANSPARENT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         pix_x,
    input  logic [7:0]         pix_y,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic               visible,
    input  logic               deal_start,
    input  logic [7:0]         start_x,
    input  logic [7:0]         start_y,
    input  logic [7:0]         target_x,
    input  logic [7:0]         target_y,
    output logic [ADDR_W-1:0]  rAddr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_valid,
    output logic               busy,
    output logic               done
);
    import card_pkg::*;

    localparam int unsigned XB = $clog2(SPR_W);
    localparam int unsigned YB = $clog2(SPR_H);

    logic [7:0]         cur_x, cur_y;
    logic [8:0]         dx, dy;
    logic               hit0;
    logic               hit1, v1;
    logic [COLOR_W-1:0] bg1;
    logic [COLOR_W-1:0] color_nxt;

    card_deal_fsm #(
        .STEP (STEP)
    ) u_deal_fsm (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .deal_start  (deal_start),
        .start_x     (start_x),
        .start_y     (start_y),
        .target_x    (target_x),
        .target_y    (target_y),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .busy        (busy),
        .done        (done)
    );

    // A borrow in dx/dy means the pixel is left of or above the card, which also
    // stops a card hanging off the right/bottom edge from wrapping to column/row 0.
    always_comb begin
        dx    = {1'b0, pix_x} - {1'b0, cur_x};
        dy    = {1'b0, pix_y} - {1'b0, cur_y};
        hit0  = pix_valid & visible & ~dx[8] & ~dy[8]
              & (dx < 9'(SPR_W)) & (dy < 9'(SPR_H));
        rAddr = '0;
        if (hit0) begin
            rAddr = ADDR_W'({dy[YB-1:0], dx[XB-1:0]});
        end
    end

    always_comb begin
        color_nxt = '0;
        if (v1) begin
            color_nxt = (hit1 && rom_data != TRANSPARENT) ? rom_data : bg1;
        end
    end

    // Stage 1 runs alongside the RAM's registered read; stage 2 composites.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit1        <= 1'b0;
            bg1         <= '0;
            v1          <= 1'b0;
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            hit1        <= hit0;
            bg1         <= bg_color;
            v1          <= pix_valid;
            color_out   <= color_nxt;
            color_valid <= v1;
        end
    end

endmodule

// File: tb/tb_card_sprite_renderer.sv
// Scoreboard bench: stimulus queues expected colours, a monitor pops on color_valid.
module tb_card_sprite_renderer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] pix_x, pix_y;
    logic       pix_valid, frame_start, visible, deal_start;
    logic [2:0] bg_color;
    logic [7:0] start_x, start_y, target_x, target_y;
    logic [8:0] rAddr;
    logic [2:0] rom_data;
    logic [2:0] color_out;
    logic       color_valid, busy, done;

    logic [2:0] ram [512];
    logic [2:0] exp_q [$];
    logic [2:0] mon_exp;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;

    card_sprite_renderer dut (
        .clock       (clock),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .bg_color    (bg_color),
        .visible     (visible),
        .deal_start  (deal_start),
        .start_x     (start_x),
        .start_y     (start_y),
        .target_x    (target_x),
        .target_y    (target_y),
        .rAddr       (rAddr),
        .rom_data    (rom_data),
        .color_out   (color_out),
        .color_valid (color_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Sprite RAM model with one-cycle registered read.
    always @(posedge clock) rom_data <= ram[rAddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    always @(negedge clock) begin
        if (color_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL color_unexpected: got color %0d with no expected pixel", color_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("color", {29'd0, color_out}, {29'd0, mon_exp});
            end
        end
    end

    task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic v, input logic vis,
                       input logic [2:0] bg, input logic [8:0] ea, input logic [2:0] ec,
                       input string name);
        @(posedge clock);
        #1;
        pix_x     = x;
        pix_y     = y;
        pix_valid = v;
        visible   = vis;
        bg_color  = bg;
        #1;
        check({name, "_addr"}, {23'd0, rAddr}, {23'd0, ea});
        if (v) exp_q.push_back(ec);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            pix_valid = 1'b0;
        end
    endtask

    task automatic frame();
        @(posedge clock);
        #1 frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
    endtask

    task automatic deal(input logic [7:0] sx, input logic [7:0] sy,
                        input logic [7:0] tx, input logic [7:0] ty);
        @(posedge clock);
        #1;
        start_x    = sx;
        start_y    = sy;
        target_x   = tx;
        target_y   = ty;
        deal_start = 1'b1;
        @(posedge clock);
        #1 deal_start = 1'b0;
    endtask

    // Card at (x,y): pixel (x+1,y+1) hits address 17 (ram 1); pixel (x-1,y+1) misses.
    task automatic probe(input logic [7:0] x, input logic [7:0] y);
        pix(x + 8'd1, y + 8'd1, 1'b1, 1'b1, 3'd6, 9'd17, 3'd1, "probe_hit");
        pix(x - 8'd1, y + 8'd1, 1'b1, 1'b1, 3'd6, 9'd0, 3'd6, "probe_miss");
        idle(1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 3'(i);
        reset = 1'b1; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
        bg_color = '0; visible = 1'b1; deal_start = 1'b0;
        start_x = '0; start_y = '0; target_x = '0; target_y = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        repeat (10) begin
            @(negedge clock);
            check("rst_color", {29'd0, color_out}, 32'd0);
            check("rst_valid", {31'd0, color_valid}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
        end

        // Card at origin.
        pix(8'd3, 8'd5, 1'b1, 1'b1, 3'd2, 9'd83, 3'd3, "base");
        pix(8'd1, 8'd0, 1'b1, 1'b1, 3'd4, 9'd1, 3'd1, "origin");
        idle(3);
        ram[83] = 3'b000;
        pix(8'd3, 8'd5, 1'b1, 1'b1, 3'd5, 9'd83, 3'd5, "transp");
        pix(8'd3, 8'd5, 1'b1, 1'b0, 3'd5, 9'd0, 3'd5, "invis_a");
        pix(8'd1, 8'd0, 1'b1, 1'b0, 3'd4, 9'd0, 3'd4, "invis_b");
        pix(8'd3, 8'd5, 1'b0, 1'b1, 3'd5, 9'd0, 3'd0, "novalid");
        pix(8'd16, 8'd5, 1'b1, 1'b1, 3'd7, 9'd0, 3'd7, "right_edge");
        idle(4);

        // Deal with start == target, used to park the card near the corner.
        deal(8'd250, 8'd230, 8'd250, 8'd230);
        check("busy_pending", {31'd0, busy}, 32'd1);
        frame();
        pix(8'd255, 8'd239, 1'b1, 1'b1, 3'd2, 9'd149, 3'd5, "clip_in");
        pix(8'd4, 8'd0, 1'b1, 1'b1, 3'd2, 9'd0, 3'd2, "clip_wrap");
        pix(8'd249, 8'd230, 1'b1, 1'b1, 3'd2, 9'd0, 3'd2, "clip_left");
        pix(8'd250, 8'd230, 1'b1, 1'b1, 3'd3, 9'd0, 3'd3, "corner");
        idle(3);
        check("busy_move_a", {31'd0, busy}, 32'd1);
        frame();
        check("done_a", {31'd0, done}, 32'd1);
        check("busy_done_a", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        check("done_a_after", {31'd0, done}, 32'd0);
        check("busy_a_after", {31'd0, busy}, 32'd0);
        check("done_cnt_a", done_cnt, 32'd1);

        // Deal (10,10)->(15,10), requested in the same cycle as a frame_start.
        @(posedge clock);
        #1;
        start_x = 8'd10; start_y = 8'd10; target_x = 8'd15; target_y = 8'd10;
        deal_start = 1'b1; frame_start = 1'b1;
        @(posedge clock);
        #1 deal_start = 1'b0; frame_start = 1'b0;
        check("busy_b", {31'd0, busy}, 32'd1);
        probe(8'd250, 8'd230);
        frame();
        probe(8'd10, 8'd10);
        deal(8'd100, 8'd100, 8'd200, 8'd200);
        frame();
        probe(8'd12, 8'd10);
        frame();
        probe(8'd14, 8'd10);
        check("done_b_early", {31'd0, done}, 32'd0);
        frame();
        check("done_b", {31'd0, done}, 32'd1);
        @(posedge clock);
        #1;
        check("done_b_after", {31'd0, done}, 32'd0);
        check("busy_b_after", {31'd0, busy}, 32'd0);
        check("done_cnt_b", done_cnt, 32'd2);
        probe(8'd15, 8'd10);
        repeat (3) @(posedge clock);
        #1 check("busy_b_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a deal.
        deal(8'd20, 8'd20, 8'd60, 8'd20);
        frame();
        frame();
        probe(8'd22, 8'd20);
        idle(4);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_valid", {31'd0, color_valid}, 32'd0);
        check("rst_mid_color", {29'd0, color_out}, 32'd0);
        pix(8'd1, 8'd1, 1'b1, 1'b1, 3'd6, 9'd17, 3'd1, "rst_cur");
        idle(3);
        frame();
        pix(8'd1, 8'd1, 1'b1, 1'b1, 3'd6, 9'd17, 3'd1, "idle_hold");
        idle(5);
        check("rst_mid_busy2", {31'd0, busy}, 32'd0);
        check("done_cnt_end", done_cnt, 32'd2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
